// File: rtl/inst_rom_loader.sv
// inst_rom_loader: OpenMIPS instruction memory, filled through a byte-serial load port.
// Optional INST_ROM_BOUNDS_EN: out-of-range fetches return NOP and raise sticky oob_err.
module inst_rom_loader #(
  parameter int DEPTH_LOG = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rom_ce,
  input  logic [31:0]          rom_addr,
  output logic [31:0]          rom_inst,
  input  logic                 load_start,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [7:0]           load_byte,
  input  logic                 load_last,
  output logic                 busy,
  output logic                 load_done,
  output logic [DEPTH_LOG:0]   word_count,
  output logic                 oob_err
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_nx;
  logic [1:0]           lane;
  logic [DEPTH_LOG-1:0] ptr;
  logic [31:0]          asm_q;
  logic [31:0]          asm_d;
  logic                 accept;
  logic                 wr_en;
  logic                 ptr_last;

  logic [31:0]          mem [DEPTH];
  logic [DEPTH_LOG-1:0] rd_idx;
  logic [31:0]          rd_word;

  assign load_ready = (state == S_FILL);
  assign busy       = (state != S_IDLE);
  assign load_done  = (state == S_DONE);

  // A byte arriving with load_start is dropped.
  assign accept   = load_valid & load_ready & ~load_start;
  assign wr_en    = accept & ((lane == 2'd3) | load_last);
  assign ptr_last = &ptr;

  // Unfilled lanes stay zero, giving the padding for a short last word.
  always_comb begin
    asm_d = asm_q;
    unique case (lane)
      2'd0: asm_d[31:24] = load_byte;
      2'd1: asm_d[23:16] = load_byte;
      2'd2: asm_d[15:8]  = load_byte;
      2'd3: asm_d[7:0]   = load_byte;
    endcase
  end

  always_comb begin
    state_nx = state;
    priority case (1'b1)
      load_start:
        state_nx = S_FILL;
      state == S_DONE:
        state_nx = S_IDLE;
      wr_en & (load_last | ptr_last):
        state_nx = S_DONE;
      state == 2'd3:
        state_nx = S_IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      lane       <= 2'd0;
      ptr        <= '0;
      word_count <= '0;
      asm_q      <= '0;
    end else begin
      state <= state_nx;
      if (load_start) begin
        lane       <= 2'd0;
        ptr        <= '0;
        word_count <= '0;
        asm_q      <= '0;
      end else if (accept) begin
        if (wr_en) begin
          lane       <= 2'd0;
          asm_q      <= '0;
          ptr        <= ptr + 1'b1;
          word_count <= word_count + 1'b1;
        end else begin
          lane  <= lane + 2'd1;
          asm_q <= asm_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[ptr] <= asm_d;
  end

  assign rd_idx  = rom_addr[DEPTH_LOG+1:2];
  assign rd_word = mem[rd_idx];

`ifdef INST_ROM_BOUNDS_EN
  logic addr_oob;
  logic misalign;
  logic fetch_act;

  assign addr_oob  = {1'b0, rom_addr} >= (33'd4 << DEPTH_LOG);
  assign misalign  = |rom_addr[1:0];
  assign fetch_act = rom_ce & ~busy;

  always_comb begin
    rom_inst = rd_word;
    if (!rst || !fetch_act || addr_oob)
      rom_inst = 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      oob_err <= 1'b0;
    else if (load_start)
      oob_err <= 1'b0;
    else if (fetch_act & (addr_oob | misalign))
      oob_err <= 1'b1;
  end
`else
  logic unused_addr;

  assign unused_addr = ^{rom_addr[31:DEPTH_LOG+2], rom_addr[1:0]};

  // Upper address bits are dropped, so fetches wrap modulo DEPTH.
  always_comb begin
    rom_inst = rd_word;
    if (!rst || !rom_ce || busy)
      rom_inst = 32'h0;
  end

  assign oob_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: two depths driven in parallel against a
// byte-image reference model, plus directed literal checks.
module tb_inst_rom_loader;

  localparam int DLB = 10;
  localparam int DLS = 2;
`ifdef INST_ROM_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = 32'h0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h0;
  logic        load_last = 1'b0;

  logic [31:0] inst_b, inst_s;
  logic        rdy_b, rdy_s, busy_b, busy_s;
  logic        done_b, done_s, oob_b, oob_s;
  logic [DLB:0] wc_b;
  logic [DLS:0] wc_s;

  always #5 clk = ~clk;

  inst_rom_loader #(.DEPTH_LOG(DLB)) u_big (
    .clk(clk), .rst(rst),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(inst_b),
    .load_start(load_start), .load_valid(load_valid),
    .load_ready(rdy_b), .load_byte(load_byte), .load_last(load_last),
    .busy(busy_b), .load_done(done_b), .word_count(wc_b),
    .oob_err(oob_b)
  );

  inst_rom_loader #(.DEPTH_LOG(DLS)) u_small (
    .clk(clk), .rst(rst),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(inst_s),
    .load_start(load_start), .load_valid(load_valid),
    .load_ready(rdy_s), .load_byte(load_byte), .load_last(load_last),
    .busy(busy_s), .load_done(done_s), .word_count(wc_s),
    .oob_err(oob_s)
  );

  logic [31:0] a_inst [2];
  logic        a_rdy  [2];
  logic        a_busy [2];
  logic        a_done [2];
  logic        a_oob  [2];
  int          a_wc   [2];

  assign a_inst[0] = inst_b;
  assign a_inst[1] = inst_s;
  assign a_rdy[0]  = rdy_b;
  assign a_rdy[1]  = rdy_s;
  assign a_busy[0] = busy_b;
  assign a_busy[1] = busy_s;
  assign a_done[0] = done_b;
  assign a_done[1] = done_s;
  assign a_oob[0]  = oob_b;
  assign a_oob[1]  = oob_s;
  assign a_wc[0]   = 32'(wc_b);
  assign a_wc[1]   = 32'(wc_s);

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 filling, 2 done pulse.
  int          dl    [2] = '{DLB, DLS};
  int          ph    [2];
  int          nb    [2];
  int          wcm   [2];
  bit          oobm  [2];
  logic [7:0]  img   [2][4096];
  logic [31:0] mm    [2][1024];
  bit          kn    [2][1024];
  int          ndone [2];
  int          nacc  [2];

  function automatic logic [31:0] pack(input int k, input int w);
    logic [31:0] r = 32'h0;
    for (int j = 0; j < 4; j++) begin
      if (4 * w + j < nb[k])
        r = {r[23:0], img[k][4 * w + j]};
      else
        r = {r[23:0], 8'h00};
    end
    return r;
  endfunction

  task automatic step(input int k);
    int  d;
    int  w;
    bit  bad;
    d = 1 << dl[k];
    if (!rst) begin
      ph[k] = 0;
      nb[k] = 0;
      wcm[k] = 0;
      oobm[k] = 1'b0;
    end else begin
      bad = rom_ce && ph[k] == 0 &&
            (longint'(rom_addr) >= 4 * d || rom_addr[1:0] != 2'b00);
      if (BOUNDS) begin
        if (load_start)
          oobm[k] = 1'b0;
        else if (bad)
          oobm[k] = 1'b1;
      end
      if (load_start) begin
        ph[k] = 1;
        nb[k] = 0;
        wcm[k] = 0;
      end else if (ph[k] == 2) begin
        ph[k] = 0;
      end else if (ph[k] == 1 && load_valid) begin
        img[k][nb[k]] = load_byte;
        nb[k]++;
        if (nb[k] % 4 == 0 || load_last) begin
          w = (nb[k] - 1) / 4;
          mm[k][w] = pack(k, w);
          kn[k][w] = 1'b1;
          wcm[k] = w + 1;
          if (load_last || wcm[k] == d)
            ph[k] = 2;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++)
      step(k);
  end

  function automatic bit exp_inst(input int k, output logic [31:0] v);
    int d;
    int idx;
    d = 1 << dl[k];
    v = 32'h0;
    if (!rst || !rom_ce || ph[k] != 0)
      return 1'b1;
    if (BOUNDS && longint'(rom_addr) >= 4 * d)
      return 1'b1;
    idx = int'(rom_addr >> 2) % d;
    if (!kn[k][idx])
      return 1'b0;
    v = mm[k][idx];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      string       p;
      logic [31:0] ev;
      p = (k == 0) ? "big" : "small";
      chk({p, ".load_ready"}, 32'(a_rdy[k]), 32'(ph[k] == 1));
      chk({p, ".busy"}, 32'(a_busy[k]), 32'(ph[k] != 0));
      chk({p, ".load_done"}, 32'(a_done[k]), 32'(ph[k] == 2));
      chk({p, ".word_count"}, 32'(a_wc[k]), 32'(wcm[k]));
      chk({p, ".oob_err"}, 32'(a_oob[k]), 32'(oobm[k]));
      if (exp_inst(k, ev))
        chk({p, ".rom_inst"}, a_inst[k], ev);
      if (a_done[k])
        ndone[k]++;
      if (load_valid && a_rdy[k] && !load_start)
        nacc[k]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte = b;
    load_last = last;
    tick();
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    rom_ce = 1'b1;
    rom_addr = a;
    #1;
  endtask

  logic [7:0] seq1 [8] = '{8'h34, 8'h02, 8'h00, 8'h01,
                           8'h24, 8'h03, 8'h00, 8'h02};
  logic [7:0] seq2 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  initial begin
    int d0;
    int a0;

    tick();
    tick();
    chk("rst.busy", 32'(busy_b), 32'h0);
    chk("rst.ready", 32'(rdy_b), 32'h0);
    rst = 1'b1;
    tick();
    chk("rel.inst", inst_b, 32'h0);
    chk("rel.wc", 32'(wc_b), 32'h0);
    chk("rel.done", 32'(done_b), 32'h0);

    start_load();
    chk("start.ready", 32'(rdy_b), 32'h1);
    chk("start.busy", 32'(busy_b), 32'h1);

    d0 = ndone[0];
    for (int i = 0; i < 8; i++)
      send(seq1[i], i == 7);
    chk("l1.done_hi", 32'(done_b), 32'h1);
    chk("l1.busy_hi", 32'(busy_b), 32'h1);
    tick();
    chk("l1.busy_lo", 32'(busy_b), 32'h0);
    chk("l1.wc", 32'(wc_b), 32'd2);
    tick();
    chk("l1.done_cnt", 32'(ndone[0] - d0), 32'd1);
    fetch(32'h0);
    chk("l1.addr0", inst_b, 32'h34020001);
    fetch(32'h4);
    chk("l1.addr4", inst_b, 32'h24030002);
    chk("l1.small4", inst_s, 32'h24030002);
    rom_ce = 1'b0;
    tick();

    start_load();
    for (int i = 0; i < 6; i++)
      send(seq2[i], i == 5);
    tick();
    tick();
    chk("l2.wc", 32'(wc_b), 32'd2);
    fetch(32'h4);
    chk("l2.pad", inst_b, 32'h55660000);
    rom_ce = 1'b0;

    start_load();
    d0 = ndone[1];
    a0 = nacc[1];
    for (int i = 0; i < 20; i++)
      send(8'(i + 1), 1'b0);
    chk("wrap.acc", 32'(nacc[1] - a0), 32'd16);
    chk("wrap.wc", 32'(wc_s), 32'd4);
    chk("wrap.ready", 32'(rdy_s), 32'h0);
    chk("wrap.done_cnt", 32'(ndone[1] - d0), 32'd1);
    chk("wrap.big_wc", 32'(wc_b), 32'd5);
    send(8'h77, 1'b1);
    tick();
    tick();
    fetch(32'hC);
    chk("wrap.small3", inst_s, 32'h0D0E0F10);
    rom_ce = 1'b0;

    d0 = ndone[0];
    start_load();
    for (int i = 0; i < 4; i++)
      send(seq1[i], 1'b0);
    send(8'h99, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid.busy", 32'(busy_b), 32'h0);
    chk("mid.ready", 32'(rdy_b), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("mid.done_cnt", 32'(ndone[0] - d0), 32'd0);
    fetch(32'h0);
    chk("mid.word0", inst_b, 32'h34020001);

    fetch(32'h00001000);
    chk("oob.inst", inst_b, BOUNDS ? 32'h0 : 32'h34020001);
    tick();
    rom_ce = 1'b0;
    chk("oob.flag", 32'(oob_b), 32'(BOUNDS));
    tick();
    chk("oob.sticky", 32'(oob_b), 32'(BOUNDS));
    start_load();
    chk("oob.clear", 32'(oob_b), 32'h0);
    send(8'hAB, 1'b1);
    tick();
    fetch(32'h2);
    chk("mis.inst", inst_b, 32'hAB000000);
    tick();
    rom_ce = 1'b0;
    chk("mis.flag", 32'(oob_b), 32'(BOUNDS));
    start_load();
    send(8'h01, 1'b1);
    tick();

    for (int c = 0; c < 4000; c++) begin
      int r;
      if (!rst)
        rst = ($urandom_range(0, 2) == 0);
      else
        rst = !($urandom_range(0, 399) == 0);
      load_start = ($urandom_range(0, 49) == 0);
      load_valid = ($urandom_range(0, 9) < 7);
      load_byte = 8'($urandom);
      load_last = ($urandom_range(0, 11) == 0);
      rom_ce = 1'($urandom);
      r = $urandom_range(0, 3);
      case (r)
        0: rom_addr = 32'($urandom_range(0, 31)) << 2;
        1: rom_addr = 32'($urandom_range(0, 63));
        2: rom_addr = $urandom;
        default: rom_addr = 32'h1000 + 32'($urandom_range(0, 15));
      endcase
      tick();
    end

    rst = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last = 1'b0;
    rom_ce = 1'b0;
    tick();
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
